cache_nway_wb: RTL and testbench

Parametrised N-way set-associative write-back data cache. It is the successor to the fixed two-way cache in the MEM stage of the five-stage pipelined CPU.
- Serves load/store requests from EXMEM in the same cycle on a hit.
- Raises `miss` to stall the pipeline while a state machine writes back a dirty victim and refills the line over a word-serial memory handshake.
- Replacement policy is selectable (LRU or FIFO).
- Keeps request and miss performance counters.

---
 rtl/cache_nway_wb.sv | 158 +++++++++++++++
 tb/tb_cache_nway_wb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative write-back data cache with LRU/FIFO replacement,
// word-serial write-back/refill FSM and request/miss counters.
module cache_nway_wb #(
   parameter int WAYS  = 4,
   parameter int SETS  = 16,
   parameter int WORDS = 4,
   parameter int REPL  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] rd_data,
   output logic        miss,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] count_wr_rd_req,
   output logic [31:0] count_cache_miss
);
   localparam int AW = $clog2(WAYS);
   localparam int IW = $clog2(SETS);
   localparam int OW = $clog2(WORDS);
   localparam int TW = 30 - IW - OW;
   typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;
   state_t r_state;
   logic [31:0]     r_data  [SETS][WAYS][WORDS];
   logic [TW-1:0]   r_tag   [SETS][WAYS];
   logic [AW-1:0]   r_age   [SETS][WAYS];
   logic [WAYS-1:0] r_valid [SETS];
   logic [WAYS-1:0] r_dirty [SETS];
   logic [AW-1:0]   r_fifo  [SETS];
   logic [IW-1:0]   r_idx;
   logic [TW-1:0]   r_rtag;
   logic [AW-1:0]   r_way;
   logic [OW-1:0]   r_beat;
   logic [OW-1:0]   w_off, w_beat_nxt;
   logic [IW-1:0]   w_idx, w_upd_idx;
   logic [TW-1:0]   w_tag;
   logic [WAYS-1:0] w_hit_vec;
   logic [AW-1:0]   w_hit_way, w_inv_way, w_lru_way, w_vict, w_upd_way;
   logic            w_req, w_hit, w_inv_any, w_last, w_upd, w_unused;
   assign w_off      = addr[2 +: OW];
   assign w_idx      = addr[2 + OW +: IW];
   assign w_tag      = addr[31 -: TW];
   assign w_unused   = ^addr[1:0];
   assign w_req      = MemRead | MemWrite;
   assign w_hit      = w_req && r_state == IDLE && |w_hit_vec;
   assign miss       = (w_req && !w_hit) || r_state != IDLE;
   assign rd_data    = w_hit ? r_data[w_idx][w_hit_way][w_off] : '0;
   assign w_beat_nxt = r_beat + 1'b1;
   assign w_last     = r_beat == OW'(WORDS - 1);
   assign w_vict     = w_inv_any ? w_inv_way : (REPL == 1 ? r_fifo[w_idx] : w_lru_way);
   assign w_upd      = w_hit || r_state == DONE;
   assign w_upd_idx  = w_hit ? w_idx : r_idx;
   assign w_upd_way  = w_hit ? w_hit_way : r_way;
   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      w_hit_vec = '0;
      w_hit_way = '0;
      w_inv_any = 1'b0;
      w_inv_way = '0;
      w_lru_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         w_hit_vec[w] = r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag;
         if (w_hit_vec[w]) w_hit_way = AW'(w);
         if (!r_valid[w_idx][w]) begin
            w_inv_any = 1'b1;
            w_inv_way = AW'(w);
         end
         if (r_age[w_idx][w] == AW'(WAYS - 1)) w_lru_way = AW'(w);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && w_hit && MemWrite) r_data[w_idx][w_hit_way][w_off] <= wr_data;
      else if (!rst && r_state == REFILL && mem_ready) r_data[r_idx][r_way][r_beat] <= mem_rdata;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= IDLE;
         mem_req          <= 1'b0;
         mem_we           <= 1'b0;
         mem_addr         <= '0;
         mem_wdata        <= '0;
         count_wr_rd_req  <= '0;
         count_cache_miss <= '0;
         r_beat           <= '0;
         r_idx            <= '0;
         r_rtag           <= '0;
         r_way            <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_fifo[s]  <= '0;
            for (int w = 0; w < WAYS; w++) r_age[s][w] <= AW'(w);
         end
      end else begin
         if (w_hit) count_wr_rd_req <= count_wr_rd_req + 32'd1;
         if (w_hit && MemWrite) r_dirty[w_idx][w_hit_way] <= 1'b1;
         if (w_upd && REPL == 0)
            for (int w = 0; w < WAYS; w++)
               if (AW'(w) == w_upd_way) r_age[w_upd_idx][w] <= '0;
               else if (r_age[w_upd_idx][w] < r_age[w_upd_idx][w_upd_way])
                  r_age[w_upd_idx][w] <= r_age[w_upd_idx][w] + 1'b1;
         case (r_state)
            IDLE: if (w_req && !w_hit) begin
               count_cache_miss <= count_cache_miss + 32'd1;
               r_idx   <= w_idx;
               r_rtag  <= w_tag;
               r_way   <= w_vict;
               r_beat  <= '0;
               mem_req <= 1'b1;
               if (r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) begin
                  r_state   <= WB;
                  mem_we    <= 1'b1;
                  mem_addr  <= {r_tag[w_idx][w_vict], w_idx, OW'(0), 2'b00};
                  mem_wdata <= r_data[w_idx][w_vict][0];
               end else begin
                  r_state  <= REFILL;
                  mem_we   <= 1'b0;
                  mem_addr <= {w_tag, w_idx, OW'(0), 2'b00};
               end
            end
            WB: if (mem_ready) begin
               r_beat <= w_beat_nxt;
               if (w_last) begin
                  r_state  <= REFILL;
                  mem_we   <= 1'b0;
                  mem_addr <= {r_rtag, r_idx, OW'(0), 2'b00};
               end else begin
                  mem_addr  <= {r_tag[r_idx][r_way], r_idx, w_beat_nxt, 2'b00};
                  mem_wdata <= r_data[r_idx][r_way][w_beat_nxt];
               end
            end
            REFILL: if (mem_ready) begin
               r_beat <= w_beat_nxt;
               if (w_last) begin
                  r_state <= DONE;
                  mem_req <= 1'b0;
               end else mem_addr <= {r_rtag, r_idx, w_beat_nxt, 2'b00};
            end
            DONE: begin
               r_state               <= IDLE;
               r_valid[r_idx][r_way] <= 1'b1;
               r_dirty[r_idx][r_way] <= 1'b0;
               r_tag[r_idx][r_way]   <= r_rtag;
               r_fifo[r_idx]         <= r_fifo[r_idx] + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_nway_wb.sv
// tb_cache_nway_wb: directed bench for cache_nway_wb; instance 0 uses LRU, instance 1 FIFO.
// Backing memory returns each word's own address.
module tb_cache_nway_wb;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr_i [2], wd_i [2], rdata [2], maddr [2], mwdata [2], cnt_req [2], cnt_miss [2];
   logic        rd_i [2], wr_i [2], miss [2], mreq [2], mwe [2], mrdy [2];
   int          wcnt [2];
   int          lat;
   int          total = 0, bad = 0;
   logic [64:0] blog [$];
   logic        m;
   logic [31:0] r;
   int          n;

   always #5 clk = ~clk;

   cache_nway_wb #(.REPL(0)) u_lru (
      .clk(clk), .rst(rst), .addr(addr_i[0]), .wr_data(wd_i[0]), .MemRead(rd_i[0]), .MemWrite(wr_i[0]),
      .rd_data(rdata[0]), .miss(miss[0]), .mem_req(mreq[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
      .mem_wdata(mwdata[0]), .mem_rdata(maddr[0]), .mem_ready(mrdy[0]),
      .count_wr_rd_req(cnt_req[0]), .count_cache_miss(cnt_miss[0]));

   cache_nway_wb #(.REPL(1)) u_fifo (
      .clk(clk), .rst(rst), .addr(addr_i[1]), .wr_data(wd_i[1]), .MemRead(rd_i[1]), .MemWrite(wr_i[1]),
      .rd_data(rdata[1]), .miss(miss[1]), .mem_req(mreq[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
      .mem_wdata(mwdata[1]), .mem_rdata(maddr[1]), .mem_ready(mrdy[1]),
      .count_wr_rd_req(cnt_req[1]), .count_cache_miss(cnt_miss[1]));

   // Each beat is acknowledged after lat wait cycles with mem_req high.
   assign mrdy[0] = mreq[0] && wcnt[0] >= lat;
   assign mrdy[1] = mreq[1] && wcnt[1] >= lat;

   always @(posedge clk)
      for (int d = 0; d < 2; d++) wcnt[d] <= (!mreq[d] || mrdy[d]) ? 0 : wcnt[d] + 1;

   always @(negedge clk)
      if (mreq[0] && mrdy[0]) blog.push_back({mwe[0], maddr[0], mwdata[0]});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic access(input int d, input logic [31:0] a, input logic we, input logic [31:0] wd,
                         output logic missed, output logic [31:0] rdat);
      int k;
      @(posedge clk);
      #1;
      addr_i[d] = a;
      wd_i[d]   = wd;
      wr_i[d]   = we;
      rd_i[d]   = !we;
      @(negedge clk);
      missed = miss[d];
      k = 0;
      while (miss[d] && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) chk("access_timeout", 32'(k), 32'd0);
      rdat = rdata[d];
      @(posedge clk);
      #1;
      rd_i[d] = 1'b0;
      wr_i[d] = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      lat = 0;
      for (int d = 0; d < 2; d++) begin
         addr_i[d] = '0;
         wd_i[d]   = '0;
         rd_i[d]   = 1'b0;
         wr_i[d]   = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_req_cnt", cnt_req[0], 32'd0);
      chk("reset_miss_cnt", cnt_miss[0], 32'd0);
      chk("reset_mem_req", 32'(mreq[0]), 32'd0);
      chk("reset_miss", 32'(miss[0]), 32'd0);

      blog.delete();
      access(0, 32'h10, 1'b0, '0, m, r);
      chk("cold_miss", 32'(m), 32'd1);
      chk("cold_beats", 32'(blog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("cold_addr", blog[i][63:32], 32'h10 + 32'(4 * i));
         chk("cold_we", 32'(blog[i][64]), 32'd0);
      end
      chk("cold_rd", r, 32'h10);
      chk("cold_req_cnt", cnt_req[0], 32'd1);
      chk("cold_miss_cnt", cnt_miss[0], 32'd1);

      blog.delete();
      access(0, 32'h14, 1'b0, '0, m, r);
      chk("line_hit", 32'(m), 32'd0);
      chk("line_rd", r, 32'h14);
      chk("line_no_beats", 32'(blog.size()), 32'd0);
      chk("line_req_cnt", cnt_req[0], 32'd2);
      chk("line_miss_cnt", cnt_miss[0], 32'd1);

      for (int i = 0; i < 4; i++) begin
         access(0, 32'(i) << 8, 1'b0, '0, m, r);
         chk("lru_fill_miss", 32'(m), 32'd1);
      end
      access(0, 32'h000, 1'b0, '0, m, r);
      chk("lru_rehit", 32'(m), 32'd0);
      access(0, 32'h400, 1'b0, '0, m, r);
      chk("lru_400_miss", 32'(m), 32'd1);
      access(0, 32'h000, 1'b0, '0, m, r);
      chk("lru_000_kept", 32'(m), 32'd0);
      blog.delete();
      access(0, 32'h100, 1'b0, '0, m, r);
      chk("lru_100_evicted", 32'(m), 32'd1);
      chk("clean_beats", 32'(blog.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("clean_no_wb", 32'(blog[i][64]), 32'd0);

      access(0, 32'h000, 1'b1, 32'hDEADBEEF, m, r);
      chk("write_hit", 32'(m), 32'd0);
      access(0, 32'h500, 1'b0, '0, m, r);
      access(0, 32'h600, 1'b0, '0, m, r);
      access(0, 32'h700, 1'b0, '0, m, r);
      blog.delete();
      access(0, 32'h800, 1'b0, '0, m, r);
      chk("dirty_miss", 32'(m), 32'd1);
      chk("dirty_beats", 32'(blog.size()), 32'd8);
      chk("wb0_we", 32'(blog[0][64]), 32'd1);
      chk("wb0_addr", blog[0][63:32], 32'h000);
      chk("wb0_data", blog[0][31:0], 32'hDEADBEEF);
      for (int i = 1; i < 4; i++) begin
         chk("wb_we", 32'(blog[i][64]), 32'd1);
         chk("wb_addr", blog[i][63:32], 32'(4 * i));
         chk("wb_data", blog[i][31:0], 32'(4 * i));
      end
      for (int i = 4; i < 8; i++) begin
         chk("refill_we", 32'(blog[i][64]), 32'd0);
         chk("refill_addr", blog[i][63:32], 32'h800 + 32'(4 * (i - 4)));
      end
      chk("dirty_rd", r, 32'h800);
      chk("lru_req_cnt", cnt_req[0], 32'd15);
      chk("lru_miss_cnt", cnt_miss[0], 32'd11);

      for (int i = 0; i < 4; i++) access(1, 32'(i) << 8, 1'b0, '0, m, r);
      access(1, 32'h000, 1'b0, '0, m, r);
      chk("fifo_rehit", 32'(m), 32'd0);
      access(1, 32'h400, 1'b0, '0, m, r);
      chk("fifo_400_miss", 32'(m), 32'd1);
      access(1, 32'h100, 1'b0, '0, m, r);
      chk("fifo_100_kept", 32'(m), 32'd0);
      chk("fifo_100_rd", r, 32'h100);
      access(1, 32'h000, 1'b0, '0, m, r);
      chk("fifo_000_evicted", 32'(m), 32'd1);
      chk("fifo_req_cnt", cnt_req[1], 32'd8);
      chk("fifo_miss_cnt", cnt_miss[1], 32'd6);

      lat = 3;
      blog.delete();
      @(posedge clk);
      #1;
      addr_i[0] = 32'h20;
      rd_i[0]   = 1'b1;
      n = 0;
      while (blog.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("rst_wait_timeout", 32'(n), 32'd0);
      @(negedge clk);
      rst     = 1'b1;
      rd_i[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_beats_before", 32'(blog.size()), 32'd2);
      chk("rst_mem_req", 32'(mreq[0]), 32'd0);
      chk("rst_miss", 32'(miss[0]), 32'd0);
      chk("rst_req_cnt", cnt_req[0], 32'd0);
      chk("rst_miss_cnt", cnt_miss[0], 32'd0);
      chk("rst_fifo_req_cnt", cnt_req[1], 32'd0);
      rst = 1'b0;
      access(0, 32'h20, 1'b0, '0, m, r);
      chk("rst_reread_miss", 32'(m), 32'd1);
      chk("rst_reread_rd", r, 32'h20);
      chk("rst_after_req_cnt", cnt_req[0], 32'd1);
      chk("rst_after_miss_cnt", cnt_miss[0], 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
